// File: rtl/piccolo_f_sched_pkg.sv
// Shared Piccolo F-function types, constants and GF(2^4) helpers.
// Latency: n/a (package only).
// Backpressure: n/a.
package piccolo_f_sched_pkg;

    localparam int NIB  = 4;
    localparam int NNIB = 4;

    // Reduction term for x^4+x+1 after the x^4 carry is dropped
    localparam logic [NIB-1:0] GF_RED = 4'h3;

    // Diffusion matrix M, row-major, row 0 produces nibble 0 (MSB nibble)
    localparam logic [NIB-1:0] M_COEF [NNIB][NNIB] = '{
        '{4'd2, 4'd3, 4'd1, 4'd1},
        '{4'd1, 4'd2, 4'd3, 4'd1},
        '{4'd1, 4'd1, 4'd2, 4'd3},
        '{4'd3, 4'd1, 4'd1, 4'd2}
    };

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        S1   = 3'd1,
        MIX  = 3'd2,
        S2   = 3'd3,
        DONE = 3'd4
    } state_t;

    function automatic logic [NIB-1:0] gf_xtime(input logic [NIB-1:0] x);
        logic [NIB-1:0] r;
        r = {x[NIB-2:0], 1'b0};
        if (x[NIB-1]) r = r ^ GF_RED;
        return r;
    endfunction

    function automatic logic [NIB-1:0] gf_mul2(input logic [NIB-1:0] x);
        return gf_xtime(x);
    endfunction

    function automatic logic [NIB-1:0] gf_mul3(input logic [NIB-1:0] x);
        return gf_xtime(x) ^ x;
    endfunction

    // Multiply by one of the small coefficients that appear in M
    function automatic logic [NIB-1:0] gf_mul_coef(input logic [NIB-1:0] c,
                                                   input logic [NIB-1:0] x);
        logic [NIB-1:0] r;
        case (c)
            4'd1:    r = x;
            4'd2:    r = gf_mul2(x);
            4'd3:    r = gf_mul3(x);
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/piccolo_f_sched_sbox4.sv
// Piccolo 4-bit S-box.
// Latency: combinational, zero cycles.
// Backpressure: none, pure lookup.
module piccolo_f_sched_sbox4
    import piccolo_f_sched_pkg::*;
(
    input  logic [NIB-1:0] sbox_in,
    output logic [NIB-1:0] sbox_out
);

    // Table lookup
    always_comb begin
        sbox_out = 4'h0;
        case (sbox_in)
            4'h0: sbox_out = 4'he;
            4'h1: sbox_out = 4'h4;
            4'h2: sbox_out = 4'hb;
            4'h3: sbox_out = 4'h2;
            4'h4: sbox_out = 4'h3;
            4'h5: sbox_out = 4'h8;
            4'h6: sbox_out = 4'h0;
            4'h7: sbox_out = 4'h9;
            4'h8: sbox_out = 4'h1;
            4'h9: sbox_out = 4'ha;
            4'ha: sbox_out = 4'h7;
            4'hb: sbox_out = 4'hf;
            4'hc: sbox_out = 4'h6;
            4'hd: sbox_out = 4'hc;
            4'he: sbox_out = 4'h5;
            4'hf: sbox_out = 4'hd;
            default: sbox_out = 4'h0;
        endcase
    end

endmodule

// File: rtl/piccolo_f_sched.sv
// Piccolo F-function (S, M, S) over one 16-bit word with a single shared S-box, one nibble per cycle.
// Latency: out_valid in the 10th cycle after accept (5th for S-layer only); one word per 11 cycles (6).
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE, no overlap of words.
module piccolo_f_sched
    import piccolo_f_sched_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [NNIB*NIB-1:0] in_data,
    input  logic                in_sonly,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [NNIB*NIB-1:0] out_data
);

    state_t              state, state_nxt;
    logic [1:0]          cnt;
    logic [NNIB*NIB-1:0] work;
    logic                sonly;
    logic [1:0]          sel;
    logic [NIB-1:0]      sbox_in, sbox_out;
    logic [NNIB*NIB-1:0] mix_out;
    logic                sub_act;

    assign sub_act   = (state == S1) || (state == S2);
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    // work is cleared on reset, and gating keeps intermediate values off the bus
    assign out_data  = out_valid ? work : '0;

    // Shared S-box select: parked on nibble 0 outside the substitution states
    assign sel = sub_act ? cnt : 2'd0;

    // Nibble mux into the S-box, MSB nibble is index 0
    always_comb begin
        sbox_in = work[15:12];
        case (sel)
            2'd0: sbox_in = work[15:12];
            2'd1: sbox_in = work[11:8];
            2'd2: sbox_in = work[7:4];
            2'd3: sbox_in = work[3:0];
            default: sbox_in = work[15:12];
        endcase
    end

    piccolo_f_sched_sbox4 u_sbox (
        .sbox_in  (sbox_in),
        .sbox_out (sbox_out)
    );

    // Diffusion layer: work = M * work over GF(2^4)
    always_comb begin
        mix_out = '0;
        for (int r = 0; r < NNIB; r++) begin
            for (int c = 0; c < NNIB; c++) begin
                mix_out[(NNIB-1-r)*NIB +: NIB] = mix_out[(NNIB-1-r)*NIB +: NIB]
                    ^ gf_mul_coef(M_COEF[r][c], work[(NNIB-1-c)*NIB +: NIB]);
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (in_valid) state_nxt = S1;
            S1:   if (cnt == 2'd3) state_nxt = sonly ? DONE : MIX;
            MIX:  state_nxt = S2;
            S2:   if (cnt == 2'd3) state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Datapath: capture, per-nibble substitution, mix, nibble counter
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= 2'd0;
            work  <= '0;
            sonly <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    work  <= in_data;
                    sonly <= in_sonly;
                    cnt   <= 2'd0;
                end
                S1, S2: begin
                    case (sel)
                        2'd0: work[15:12] <= sbox_out;
                        2'd1: work[11:8]  <= sbox_out;
                        2'd2: work[7:4]   <= sbox_out;
                        2'd3: work[3:0]   <= sbox_out;
                        default: work[15:12] <= sbox_out;
                    endcase
                    cnt <= cnt + 2'd1;
                end
                MIX: work <= mix_out;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_piccolo_f_sched.sv
module tb_piccolo_f_sched;
    import piccolo_f_sched_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        in_sonly;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;

    int n_tests = 0;
    int n_fail  = 0;

    piccolo_f_sched dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sonly  (in_sonly),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a word and wait for the accepting edge; returns with time just past that edge
    task automatic accept(input logic [15:0] d, input logic so);
        int n;
        n = 0;
        in_data  = d;
        in_sonly = so;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        chk("accept_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        in_data  = 16'h0;
        in_sonly = 1'b0;
    endtask

    // One full transaction; hold = cycles of out_ready low in DONE
    task automatic run_word(input string tag, input logic [15:0] d, input logic so,
                            input logic [15:0] exp, input int exp_lat, input int hold);
        int  cyc;
        bit  rdy_hi;
        bit  mix_seen;
        bit  unstable;
        logic [15:0] held;
        accept(d, so);
        cyc      = 1;
        rdy_hi   = 0;
        mix_seen = 0;
        while (!out_valid && cyc < 40) begin
            if (in_ready) rdy_hi = 1;
            if (dut.state == MIX || dut.state == S2) mix_seen = 1;
            tick();
            cyc++;
        end
        chk({tag, "_lat"}, 32'(cyc), 32'(exp_lat));
        chk({tag, "_data"}, 32'(out_data), 32'(exp));
        chk({tag, "_inrdy_low"}, 32'(rdy_hi), 32'd0);
        if (so) chk({tag, "_no_mix"}, 32'(mix_seen), 32'd0);
        if (hold > 0) begin
            unstable = 0;
            held = out_data;
            for (int i = 0; i < hold; i++) begin
                in_valid = i[0];
                in_data  = 16'hBEEF;
                tick();
                if (!out_valid || out_data !== held || in_ready) unstable = 1;
            end
            in_valid = 1'b0;
            chk({tag, "_bp_stable"}, 32'(unstable), 32'd0);
            chk({tag, "_bp_data"}, 32'(out_data), 32'(exp));
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_ovld_drop"}, 32'(out_valid), 32'd0);
        chk({tag, "_idle_rdy"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 16'h0;
        in_sonly  = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'h0);

        // Directed vectors, hand-computed through S, M, S
        run_word("f0000", 16'h0000, 1'b0, 16'h5555, 10, 0);
        run_word("fffff", 16'hFFFF, 1'b0, 16'hCCCC, 10, 0);
        run_word("f1000", 16'h1000, 1'b0, 16'hA332, 10, 0);
        run_word("s0123", 16'h0123, 1'b1, 16'hE4B2, 5, 0);
        run_word("bp",    16'h1000, 1'b0, 16'hA332, 10, 7);

        // Reset while S2 is on its third nibble
        accept(16'h0000, 1'b0);
        for (int i = 0; i < 7; i++) tick();
        chk("mid_in_s2", 32'(dut.state == S2), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_ovld", 32'(out_valid), 32'd0);
        chk("mid_rst_inrdy", 32'(in_ready), 32'd1);
        chk("mid_rst_data", 32'(out_data), 32'h0);
        run_word("post_rst", 16'h0000, 1'b0, 16'h5555, 10, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
